// File: rtl/i2s_dac_tx.sv
// I2S transmitter for a stereo audio DAC: divides clk into BCLK, frames 64 BCLKs
// per LRCK period and shifts a double-buffered sample pair out MSB first.
module i2s_dac_tx #(
  parameter int DATA_W    = 16,
  parameter int BCLK_HALF = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              pll_locked,
  input  logic              sample_valid,
  input  logic [DATA_W-1:0] sample_l,
  input  logic [DATA_W-1:0] sample_r,
  output logic              sample_ready,
  output logic              aud_bclk,
  output logic              aud_daclrck,
  output logic              aud_dacdat,
  output logic              underrun,
  output logic [15:0]       underrun_cnt
);

  localparam logic [4:0] DIV_LAST = 5'(2 * BCLK_HALF - 1);
  localparam logic [4:0] DIV_HALF = 5'(BCLK_HALF);
  localparam logic [5:0] DW       = 6'(DATA_W);

  logic [4:0]        div_cnt;
  logic [5:0]        bit_cnt;
  logic              hold_full;
  logic [DATA_W-1:0] hold_l;
  logic [DATA_W-1:0] hold_r;
  logic [DATA_W-1:0] active_l;
  logic [DATA_W-1:0] active_r;

  logic              div_wrap;
  logic [4:0]        div_nxt;
  logic              fall;
  logic              frame_start;
  logic              accept;
  logic              hold_full_nxt;
  logic [5:0]        bit_nxt;
  logic [5:0]        slot_idx;
  logic [DATA_W-1:0] chan;
  logic [DATA_W-1:0] chan_sh;
  logic              dat_nxt;

  always_comb begin
    div_wrap      = (div_cnt == DIV_LAST);
    div_nxt       = div_wrap ? 5'd0 : div_cnt + 5'd1;
    fall          = pll_locked && div_wrap;
    frame_start   = fall && (bit_cnt == 6'd63);
    accept        = sample_valid && sample_ready;
    // accept only happens while empty, so it never collides with a frame-start drain
    hold_full_nxt = accept ? 1'b1 : (frame_start ? 1'b0 : hold_full);
    bit_nxt       = bit_cnt + 6'd1;
    chan          = bit_nxt[5] ? active_r : active_l;
    slot_idx      = DW - {1'b0, bit_nxt[4:0]};
    chan_sh       = chan >> slot_idx;
    // slot 0 is the I2S one-BCLK delay; slots past the sample width pad with zeros
    dat_nxt       = (bit_nxt[4:0] != 5'd0) && ({1'b0, bit_nxt[4:0]} <= DW) && chan_sh[0];
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      div_cnt      <= 5'd0;
      bit_cnt      <= 6'd63;
      aud_bclk     <= 1'b0;
      aud_daclrck  <= 1'b1;
      aud_dacdat   <= 1'b0;
      hold_full    <= 1'b0;
      hold_l       <= '0;
      hold_r       <= '0;
      active_l     <= '0;
      active_r     <= '0;
      sample_ready <= 1'b1;
      underrun     <= 1'b0;
      underrun_cnt <= 16'd0;
    end else begin
      underrun <= 1'b0;

      if (pll_locked) begin
        div_cnt  <= div_nxt;
        aud_bclk <= (div_nxt >= DIV_HALF);
      end

      if (fall) begin
        bit_cnt     <= bit_nxt;
        aud_daclrck <= bit_nxt[5];
        aud_dacdat  <= dat_nxt;
      end

      if (frame_start) begin
        if (hold_full) begin
          active_l <= hold_l;
          active_r <= hold_r;
        end else begin
          active_l <= '0;
          active_r <= '0;
          underrun <= 1'b1;
          if (underrun_cnt != 16'hFFFF) begin
            underrun_cnt <= underrun_cnt + 16'd1;
          end
        end
      end

      if (accept) begin
        hold_l <= sample_l;
        hold_r <= sample_r;
      end
      hold_full    <= hold_full_nxt;
      sample_ready <= !hold_full_nxt;
    end
  end

endmodule

// File: tb/tb_i2s_dac_tx.sv
// Directed bench for i2s_dac_tx at default parameters (6 clk per BCLK, 384 clk per frame).
module tb_i2s_dac_tx;

  logic        clk;
  logic        rst_n;
  logic        pll_locked;
  logic        sample_valid;
  logic [15:0] sample_l;
  logic [15:0] sample_r;
  logic        sample_ready;
  logic        aud_bclk;
  logic        aud_daclrck;
  logic        aud_dacdat;
  logic        underrun;
  logic [15:0] underrun_cnt;

  int checks = 0;
  int passed = 0;

  i2s_dac_tx dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .pll_locked   (pll_locked),
    .sample_valid (sample_valid),
    .sample_l     (sample_l),
    .sample_r     (sample_r),
    .sample_ready (sample_ready),
    .aud_bclk     (aud_bclk),
    .aud_daclrck  (aud_daclrck),
    .aud_dacdat   (aud_dacdat),
    .underrun     (underrun),
    .underrun_cnt (underrun_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Leaves rst_n released just after an edge; the next posedge is edge 1.
  task automatic apply_reset();
    rst_n        = 1'b0;
    pll_locked   = 1'b1;
    sample_valid = 1'b0;
    step(2);
    rst_n = 1'b1;
  endtask

  // Called just after a frame-start edge; samples dacdat on each BCLK rise, ends on the next frame start.
  task automatic capture_frame(output logic [63:0] w);
    w = '0;
    for (int n = 0; n < 64; n++) begin
      step(3);
      w = {w[62:0], aud_dacdat};
      step(3);
    end
  endtask

  task automatic test_reset();
    rst_n        = 1'b0;
    pll_locked   = 1'b1;
    sample_valid = 1'b0;
    sample_l     = 16'h0;
    sample_r     = 16'h0;
    step(2);
    checks++; if (aud_bclk !== 1'b0) $display("FAIL reset_bclk: got %b want 0", aud_bclk); else passed++;
    checks++; if (aud_daclrck !== 1'b1) $display("FAIL reset_lrck: got %b want 1", aud_daclrck); else passed++;
    checks++; if (aud_dacdat !== 1'b0) $display("FAIL reset_dat: got %b want 0", aud_dacdat); else passed++;
    checks++; if (sample_ready !== 1'b1) $display("FAIL reset_ready: got %b want 1", sample_ready); else passed++;
    checks++; if (underrun !== 1'b0) $display("FAIL reset_underrun: got %b want 0", underrun); else passed++;
    checks++; if (underrun_cnt !== 16'd0) $display("FAIL reset_cnt: got %0d want 0", underrun_cnt); else passed++;
  endtask

  task automatic test_first_frame();
    logic [63:0] w;
    logic [63:0] exp_w;
    apply_reset();
    sample_valid = 1'b1;
    sample_l     = 16'h8001;
    sample_r     = 16'h7FFE;
    step(1);
    checks++; if (sample_ready !== 1'b0) $display("FAIL first_ready_after_accept: got %b want 0", sample_ready); else passed++;
    sample_valid = 1'b0;
    sample_l     = 16'h0000;
    sample_r     = 16'h0000;
    step(4);
    checks++; if (aud_daclrck !== 1'b1) $display("FAIL first_lrck_edge5: got %b want 1", aud_daclrck); else passed++;
    step(1);
    checks++; if (aud_daclrck !== 1'b0) $display("FAIL first_lrck_edge6: got %b want 0", aud_daclrck); else passed++;
    checks++; if (underrun !== 1'b0) $display("FAIL first_no_underrun: got %b want 0", underrun); else passed++;
    checks++; if (sample_ready !== 1'b1) $display("FAIL first_ready_drained: got %b want 1", sample_ready); else passed++;
    capture_frame(w);
    exp_w = {1'b0, 16'h8001, 15'h0, 1'b0, 16'h7FFE, 15'h0};
    checks++; if (w !== exp_w) $display("FAIL first_frame_bits: got %h want %h", w, exp_w); else passed++;
    checks++; if (underrun !== 1'b1) $display("FAIL first_next_underrun: got %b want 1", underrun); else passed++;
    checks++; if (underrun_cnt !== 16'd1) $display("FAIL first_next_cnt: got %0d want 1", underrun_cnt); else passed++;
  endtask

  task automatic test_underrun();
    int ucount;
    int spacing_err;
    int dat_err;
    apply_reset();
    step(6);
    checks++; if (underrun !== 1'b1) $display("FAIL ur_first_pulse: got %b want 1", underrun); else passed++;
    ucount = (underrun === 1'b1) ? 1 : 0;
    spacing_err = 0;
    dat_err = 0;
    for (int i = 1; i <= 768; i++) begin
      step(1);
      if (aud_dacdat !== 1'b0) dat_err++;
      if (underrun === 1'b1) begin
        ucount++;
        if (i % 384 != 0) spacing_err++;
      end
    end
    checks++; if (ucount !== 3) $display("FAIL ur_pulse_count: got %0d want 3", ucount); else passed++;
    checks++; if (spacing_err !== 0) $display("FAIL ur_spacing: got %0d off-grid pulses want 0", spacing_err); else passed++;
    checks++; if (underrun_cnt !== 16'd3) $display("FAIL ur_cnt: got %0d want 3", underrun_cnt); else passed++;
    checks++; if (dat_err !== 0) $display("FAIL ur_dat_zero: got %0d nonzero cycles want 0", dat_err); else passed++;
  endtask

  task automatic test_valid_at_frame_start();
    logic [63:0] w;
    logic [63:0] exp_w;
    apply_reset();
    step(5);
    sample_valid = 1'b1;
    sample_l     = 16'hA5A5;
    sample_r     = 16'h0F0F;
    step(1);
    checks++; if (underrun !== 1'b1) $display("FAIL vfs_underrun: got %b want 1", underrun); else passed++;
    checks++; if (sample_ready !== 1'b0) $display("FAIL vfs_ready: got %b want 0", sample_ready); else passed++;
    sample_valid = 1'b0;
    capture_frame(w);
    checks++; if (w !== 64'h0) $display("FAIL vfs_silent_frame: got %h want 0", w); else passed++;
    checks++; if (underrun !== 1'b0) $display("FAIL vfs_second_no_underrun: got %b want 0", underrun); else passed++;
    checks++; if (sample_ready !== 1'b1) $display("FAIL vfs_second_ready: got %b want 1", sample_ready); else passed++;
    capture_frame(w);
    exp_w = {1'b0, 16'hA5A5, 15'h0, 1'b0, 16'h0F0F, 15'h0};
    checks++; if (w !== exp_w) $display("FAIL vfs_frame_bits: got %h want %h", w, exp_w); else passed++;
  endtask

  task automatic test_back_to_back();
    int p, acc_cnt, last_acc, bad_gap, dat_err, ur_seen, rdy_hi, n, s, f;
    logic acc;
    logic expb;
    logic [15:0] wv;
    logic [15:0] sh;
    apply_reset();
    p = 0; acc_cnt = 0; last_acc = 0; bad_gap = 0; dat_err = 0; ur_seen = 0; rdy_hi = 0;
    for (int e = 1; e <= 1158; e++) begin
      sample_valid = 1'b1;
      sample_l     = 16'h8100 + 16'(p);
      sample_r     = 16'h4200 + 16'(3 * p);
      acc = sample_ready;
      step(1);
      if (acc === 1'b1) begin
        acc_cnt++;
        if (acc_cnt > 2 && (e - last_acc) != 384) bad_gap++;
        last_acc = e;
        p++;
      end
      if (sample_ready === 1'b1) rdy_hi++;
      if (underrun === 1'b1) ur_seen++;
      if (e >= 6 && (e - 6) % 6 == 3) begin
        n  = ((e - 6) / 6) % 64;
        f  = (e - 6) / 384;
        s  = n % 32;
        wv = (n >= 32) ? 16'h4200 + 16'(3 * f) : 16'h8100 + 16'(f);
        sh = wv >> (16 - s);
        expb = (s >= 1 && s <= 16) ? sh[0] : 1'b0;
        if (aud_dacdat !== expb) dat_err++;
      end
    end
    sample_valid = 1'b0;
    checks++; if (acc_cnt !== 4) $display("FAIL b2b_accepts: got %0d want 4", acc_cnt); else passed++;
    checks++; if (bad_gap !== 0) $display("FAIL b2b_gap: got %0d bad gaps want 0", bad_gap); else passed++;
    checks++; if (rdy_hi !== 4) $display("FAIL b2b_ready_high_cycles: got %0d want 4", rdy_hi); else passed++;
    checks++; if (ur_seen !== 0) $display("FAIL b2b_underruns: got %0d want 0", ur_seen); else passed++;
    checks++; if (dat_err !== 0) $display("FAIL b2b_data: got %0d bad bits want 0", dat_err); else passed++;
    checks++; if (underrun_cnt !== 16'd0) $display("FAIL b2b_cnt: got %0d want 0", underrun_cnt); else passed++;
  endtask

  task automatic test_pll_freeze();
    logic [63:0] w;
    logic [63:0] exp_w;
    logic hb, hl, hd;
    logic prev;
    int nbits, frz_err;
    apply_reset();
    sample_valid = 1'b1;
    sample_l     = 16'hB38F;
    sample_r     = 16'h5A3C;
    step(1);
    sample_valid = 1'b0;
    step(5);
    w = '0; nbits = 0; frz_err = 0;
    hb = 1'b0; hl = 1'b0; hd = 1'b0;
    prev = aud_bclk;
    for (int c = 1; c <= 484; c++) begin
      pll_locked = (c >= 32 && c < 132) ? 1'b0 : 1'b1;
      if (c == 32) begin hb = aud_bclk; hl = aud_daclrck; hd = aud_dacdat; end
      sample_valid = (c == 50);
      sample_l     = 16'h1234;
      sample_r     = 16'h4321;
      step(1);
      if (c >= 32 && c < 132) begin
        if (aud_bclk !== hb || aud_daclrck !== hl || aud_dacdat !== hd) frz_err++;
      end
      if (c == 50) begin
        checks++; if (sample_ready !== 1'b0) $display("FAIL frz_accept_while_unlocked: got ready %b want 0", sample_ready); else passed++;
      end
      if (c == 483) begin
        checks++; if (sample_ready !== 1'b0) $display("FAIL frz_no_early_frame: got ready %b want 0", sample_ready); else passed++;
      end
      if (aud_bclk === 1'b1 && prev === 1'b0) begin
        w = {w[62:0], aud_dacdat};
        nbits++;
      end
      prev = aud_bclk;
    end
    sample_valid = 1'b0;
    pll_locked   = 1'b1;
    exp_w = {1'b0, 16'hB38F, 15'h0, 1'b0, 16'h5A3C, 15'h0};
    checks++; if (frz_err !== 0) $display("FAIL frz_outputs_held: got %0d changes want 0", frz_err); else passed++;
    checks++; if (nbits !== 64) $display("FAIL frz_bit_count: got %0d want 64", nbits); else passed++;
    checks++; if (w !== exp_w) $display("FAIL frz_frame_bits: got %h want %h", w, exp_w); else passed++;
    checks++; if (sample_ready !== 1'b1) $display("FAIL frz_frame_start_on_time: got ready %b want 1", sample_ready); else passed++;
    checks++; if (underrun_cnt !== 16'd0) $display("FAIL frz_cnt: got %0d want 0", underrun_cnt); else passed++;
  endtask

  task automatic test_reset_mid_frame();
    apply_reset();
    step(6);
    sample_valid = 1'b1;
    sample_l     = 16'hFFFF;
    sample_r     = 16'hFFFF;
    step(1);
    sample_valid = 1'b0;
    step(383);
    sample_valid = 1'b1;
    step(1);
    sample_valid = 1'b0;
    step(49);
    checks++; if (aud_dacdat !== 1'b1) $display("FAIL rmf_pre_dat: got %b want 1", aud_dacdat); else passed++;
    checks++; if (sample_ready !== 1'b0) $display("FAIL rmf_pre_ready: got %b want 0", sample_ready); else passed++;
    checks++; if (underrun_cnt !== 16'd1) $display("FAIL rmf_pre_cnt: got %0d want 1", underrun_cnt); else passed++;
    rst_n = 1'b0;
    step(1);
    checks++; if (aud_bclk !== 1'b0) $display("FAIL rmf_bclk: got %b want 0", aud_bclk); else passed++;
    checks++; if (aud_daclrck !== 1'b1) $display("FAIL rmf_lrck: got %b want 1", aud_daclrck); else passed++;
    checks++; if (aud_dacdat !== 1'b0) $display("FAIL rmf_dat: got %b want 0", aud_dacdat); else passed++;
    checks++; if (sample_ready !== 1'b1) $display("FAIL rmf_ready: got %b want 1", sample_ready); else passed++;
    checks++; if (underrun_cnt !== 16'd0) $display("FAIL rmf_cnt: got %0d want 0", underrun_cnt); else passed++;
    rst_n = 1'b1;
    step(6);
    checks++; if (underrun !== 1'b1) $display("FAIL rmf_holding_discarded: got underrun %b want 1", underrun); else passed++;
    checks++; if (underrun_cnt !== 16'd1) $display("FAIL rmf_post_cnt: got %0d want 1", underrun_cnt); else passed++;
  endtask

  initial begin
    test_reset();
    test_first_frame();
    test_underrun();
    test_valid_at_frame_start();
    test_back_to_back();
    test_pll_freeze();
    test_reset_mid_frame();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
